// File: rtl/riscv_pkg.sv
// Shared types and defaults for the multi-port integer register file.
// Register index width, XLEN/NREGS defaults and the clear sequencer states.
package riscv_pkg;

    localparam int REG_IDX_W = 5;
    localparam int XLEN_DEF  = 64;
    localparam int NREGS_DEF = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

endpackage

// File: rtl/riscv_regfile_clr_seq.sv
// Clear sequencer: walks x1..x(NREGS-1) writing zero, one register per cycle.
// Asserts clr_start_o on the accepting edge so the scoreboard drops all pend bits.
module riscv_regfile_clr_seq
    import riscv_pkg::*;
#(
    parameter int NREGS = NREGS_DEF
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 clear_i,
    output logic                 busy_o,
    output logic                 clr_we_o,
    output logic                 clr_start_o,
    output logic [REG_IDX_W-1:0] clr_idx_o
);

    localparam logic [REG_IDX_W-1:0] LAST = REG_IDX_W'(NREGS - 1);
    localparam logic [REG_IDX_W-1:0] FIRST = REG_IDX_W'(1);

    clr_state_e           state_q, state_d;
    logic [REG_IDX_W-1:0] idx_q, idx_d;

    // State and index registers; reset aborts any clear in progress.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            idx_q   <= FIRST;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next state, index advance and per-cycle clear strobes.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        busy_o      = 1'b0;
        clr_we_o    = 1'b0;
        clr_start_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (clear_i) begin
                    state_d     = CLEAR;
                    idx_d       = FIRST;
                    clr_start_o = 1'b1;
                end
            end
            CLEAR: begin
                busy_o   = 1'b1;
                clr_we_o = 1'b1;
                if (idx_q == LAST) begin
                    state_d = IDLE;
                    idx_d   = FIRST;
                end else begin
                    idx_d = idx_q + FIRST;
                end
            end
        endcase
    end

    assign clr_idx_o = idx_q;

endmodule

// File: rtl/riscv_regfile_mp.sv
// Multi-port integer register file: NRD async reads, two writes, pend scoreboard.
// Optional same-cycle write-to-read bypass under RISCV_REGFILE_BYPASS_EN.
module riscv_regfile_mp
    import riscv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = 2
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     clear_i,
    output logic                     busy_o,
    input  logic                     we0_i,
    input  logic [REG_IDX_W-1:0]     waddr0_i,
    input  logic [XLEN-1:0]          wdata0_i,
    input  logic                     we1_i,
    input  logic [REG_IDX_W-1:0]     waddr1_i,
    input  logic [XLEN-1:0]          wdata1_i,
    input  logic [NRD*REG_IDX_W-1:0] raddr_i,
    output logic [NRD*XLEN-1:0]      rdata_o,
    input  logic                     rsv_i,
    input  logic [REG_IDX_W-1:0]     rsv_addr_i,
    output logic [NREGS-1:0]         pend_o
);

    logic                 busy;
    logic                 clr_we;
    logic                 clr_start;
    logic [REG_IDX_W-1:0] clr_idx;

    logic [XLEN-1:0]  regs_q [1:NREGS-1];
    logic [NREGS-1:1] pend_q;
    logic [NREGS-1:1] hit0, hit1, hitc, hitr;

    riscv_regfile_clr_seq #(
        .NREGS(NREGS)
    ) u_clr_seq (
        .clk        (clk),
        .rstn       (rstn),
        .clear_i    (clear_i),
        .busy_o     (busy),
        .clr_we_o   (clr_we),
        .clr_start_o(clr_start),
        .clr_idx_o  (clr_idx)
    );

    assign busy_o = busy;

    // Per-register decode; indices outside 1..NREGS-1 never match.
    always_comb begin
        hit0 = '0;
        hit1 = '0;
        hitc = '0;
        hitr = '0;
        for (int r = 1; r < NREGS; r++) begin
            hit0[r] = we0_i && !busy && (waddr0_i == REG_IDX_W'(r));
            hit1[r] = we1_i && !busy && (waddr1_i == REG_IDX_W'(r));
            hitc[r] = clr_we && (clr_idx == REG_IDX_W'(r));
            hitr[r] = rsv_i && !busy && (rsv_addr_i == REG_IDX_W'(r));
        end
    end

    // Register storage; clear strobe first, then port 1 over port 0.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int r = 1; r < NREGS; r++) regs_q[r] <= '0;
        end else begin
            for (int r = 1; r < NREGS; r++) begin
                if (hitc[r])      regs_q[r] <= '0;
                else if (hit1[r]) regs_q[r] <= wdata1_i;
                else if (hit0[r]) regs_q[r] <= wdata0_i;
            end
        end
    end

    // Pending scoreboard; a reservation beats a same-cycle write (younger producer).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pend_q <= '0;
        end else if (clr_start) begin
            pend_q <= '0;
        end else begin
            pend_q <= (pend_q & ~(hit0 | hit1)) | hitr;
        end
    end

    assign pend_o = {pend_q, 1'b0};

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [REG_IDX_W-1:0] ra;
        logic [XLEN-1:0]      rd;

        assign ra = raddr_i[REG_IDX_W*k +: REG_IDX_W];

        // Read mux: x0 and out-of-range indices fall through to zero.
        always_comb begin
            rd = '0;
            for (int r = 1; r < NREGS; r++) begin
                if (ra == REG_IDX_W'(r)) begin
`ifdef RISCV_REGFILE_BYPASS_EN
                    if (hit1[r])      rd = wdata1_i;
                    else if (hit0[r]) rd = wdata0_i;
                    else              rd = regs_q[r];
`else
                    rd = regs_q[r];
`endif
                end
            end
        end

        assign rdata_o[XLEN*k +: XLEN] = rd;
    end

endmodule

// File: tb/tb_riscv_regfile_mp.sv
// Self-checking bench for riscv_regfile_mp (64x32 and 32x16 instances).
// Table-driven write/read vectors through a queue plus clear/reset sequences.
module tb_riscv_regfile_mp;

    logic clk = 1'b0;
    logic rstn = 1'b0;

    always #5 clk = ~clk;

    // Main instance: XLEN=64, NREGS=32, NRD=2
    logic         clear, busy, we0, we1, rsv;
    logic [4:0]   wa0, wa1, rsva;
    logic [63:0]  wd0, wd1;
    logic [9:0]   raddr;
    logic [127:0] rdata;
    logic [31:0]  pend;

    // Small instance: XLEN=32, NREGS=16, NRD=2
    logic         clear_s, busy_s, we0_s, we1_s, rsv_s;
    logic [4:0]   wa0_s, wa1_s, rsva_s;
    logic [31:0]  wd0_s, wd1_s;
    logic [9:0]   raddr_s;
    logic [63:0]  rdata_s;
    logic [15:0]  pend_s;

    riscv_regfile_mp #(.XLEN(64), .NREGS(32), .NRD(2)) dut (
        .clk(clk), .rstn(rstn), .clear_i(clear), .busy_o(busy),
        .we0_i(we0), .waddr0_i(wa0), .wdata0_i(wd0),
        .we1_i(we1), .waddr1_i(wa1), .wdata1_i(wd1),
        .raddr_i(raddr), .rdata_o(rdata),
        .rsv_i(rsv), .rsv_addr_i(rsva), .pend_o(pend)
    );

    riscv_regfile_mp #(.XLEN(32), .NREGS(16), .NRD(2)) dut16 (
        .clk(clk), .rstn(rstn), .clear_i(clear_s), .busy_o(busy_s),
        .we0_i(we0_s), .waddr0_i(wa0_s), .wdata0_i(wd0_s),
        .we1_i(we1_s), .waddr1_i(wa1_s), .wdata1_i(wd1_s),
        .raddr_i(raddr_s), .rdata_o(rdata_s),
        .rsv_i(rsv_s), .rsv_addr_i(rsva_s), .pend_o(pend_s)
    );

    typedef struct {
        logic        we0;
        logic [4:0]  a0;
        logic [63:0] d0;
        logic        we1;
        logic [4:0]  a1;
        logic [63:0] d1;
        logic [4:0]  r0;
        logic [63:0] e0;
        logic [4:0]  r1;
        logic [63:0] e1;
    } vec_t;

    vec_t        vecs[6];
    logic [63:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cnt;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        clear = 0; we0 = 0; we1 = 0; rsv = 0;
        wa0 = 0; wa1 = 0; rsva = 0; wd0 = 0; wd1 = 0; raddr = 0;
        clear_s = 0; we0_s = 0; we1_s = 0; rsv_s = 0;
        wa0_s = 0; wa1_s = 0; rsva_s = 0; wd0_s = 0; wd1_s = 0; raddr_s = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{1'b1, 5'd5, 64'h1111, 1'b1, 5'd5, 64'h2222,
                    5'd5, 64'h2222, 5'd0, 64'h0};
        vecs[1] = '{1'b1, 5'd0, 64'hFF, 1'b0, 5'd0, 64'h0,
                    5'd0, 64'h0, 5'd5, 64'h2222};
        vecs[2] = '{1'b1, 5'd6, 64'h66, 1'b1, 5'd0, 64'hFF,
                    5'd6, 64'h66, 5'd0, 64'h0};
        vecs[3] = '{1'b1, 5'd9, 64'hDEADBEEF_CAFEF00D, 1'b1, 5'd10, 64'h1234,
                    5'd9, 64'hDEADBEEF_CAFEF00D, 5'd10, 64'h1234};
        vecs[4] = '{1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 5'd1, 64'h1,
                    5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd1, 64'h1};
        vecs[5] = '{1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0,
                    5'd10, 64'h1234, 5'd6, 64'h66};

        idle_inputs();
        rstn = 0;
        repeat (3) @(posedge clk);
        #1 rstn = 1;

        // Reset state: every index on every port reads zero
        @(negedge clk);
        chk("rst_pend", 64'(pend), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_pend16", 64'(pend_s), 64'h0);
        for (int i = 0; i < 32; i++) begin
            raddr = {5'(i), 5'(i)};
            raddr_s = {5'(i), 5'(i)};
            #1;
            chk("rst_rd0", rdata[63:0], 64'h0);
            chk("rst_rd1", rdata[127:64], 64'h0);
            chk("rst_rd16", 64'(rdata_s), 64'h0);
        end

        // Table of write-then-read vectors, expectations via queue
        for (int i = 0; i < 6; i++) begin
            step();
            we0 = vecs[i].we0; wa0 = vecs[i].a0; wd0 = vecs[i].d0;
            we1 = vecs[i].we1; wa1 = vecs[i].a1; wd1 = vecs[i].d1;
            step();
            we0 = 0; we1 = 0;
            raddr = {vecs[i].r1, vecs[i].r0};
            exp_q.push_back(vecs[i].e0);
            exp_q.push_back(vecs[i].e1);
            @(negedge clk);
            chk("vec_rd0", rdata[63:0], exp_q.pop_front());
            chk("vec_rd1", rdata[127:64], exp_q.pop_front());
        end

        // Same-cycle write/read of x7
        step();
        we0 = 1; wa0 = 7; wd0 = 64'hABCD; raddr = {5'd5, 5'd7};
        @(negedge clk);
`ifdef RISCV_REGFILE_BYPASS_EN
        chk("byp_same", rdata[63:0], 64'hABCD);
`else
        chk("byp_same", rdata[63:0], 64'h0);
`endif
        chk("byp_other", rdata[127:64], 64'h2222);
        step();
        we0 = 0;
        @(negedge clk);
        chk("byp_next", rdata[63:0], 64'hABCD);

        // Scoreboard: reserve, then write clears; same-cycle set wins
        step();
        rsv = 1; rsva = 3;
        @(negedge clk);
        chk("pend3_pre", 64'(pend[3]), 64'h0);
        step();
        rsv = 0;
        @(negedge clk);
        chk("pend3_set", 64'(pend[3]), 64'h1);
        step();
        we0 = 1; wa0 = 3; wd0 = 64'h33;
        step();
        we0 = 0;
        @(negedge clk);
        chk("pend3_clr", 64'(pend), 64'h0);
        step();
        rsv = 1; rsva = 4; we0 = 1; wa0 = 4; wd0 = 64'h44;
        step();
        rsv = 0; we0 = 0; raddr = {5'd0, 5'd4};
        @(negedge clk);
        chk("pend4_win", 64'(pend), 64'h10);
        chk("x4_written", rdata[63:0], 64'h44);

        // Fill every register, reserve x8, then run a clear
        for (int i = 1; i < 32; i++) begin
            step();
            we0 = 1; wa0 = 5'(i); wd0 = 64'h0101_0101_0101_0101 * 64'(i);
        end
        step();
        we0 = 0; rsv = 1; rsva = 8; raddr = {5'd31, 5'd17};
        @(negedge clk);
        chk("fill_x17", rdata[63:0], 64'h1111_1111_1111_1111);
        chk("fill_x31", rdata[127:64], 64'h1F1F_1F1F_1F1F_1F1F);
        step();
        rsv = 0;
        @(negedge clk);
        chk("pend8", 64'(pend), 64'h100);
        step();
        clear = 1;
        step();
        clear = 0; we0 = 1; wa0 = 1; wd0 = 64'hBAD; rsv = 1; rsva = 2;
        raddr = {5'd31, 5'd1};
        cnt = 0;
        @(negedge clk);
        chk("clr_pend", 64'(pend), 64'h0);
        chk("clr_x1_hold", rdata[63:0], 64'h0101_0101_0101_0101);
        for (int c = 0; c < 100; c++) begin
            if (!busy) break;
            cnt++;
            @(negedge clk);
        end
        rsv = 0;
        chk("busy_len", 64'(cnt), 64'd31);
        step();
        we0 = 0;
        @(negedge clk);
        chk("wr_on_fall", rdata[63:0], 64'hBAD);
        chk("clr_pend_after", 64'(pend), 64'h0);
        for (int i = 2; i < 32; i++) begin
            raddr = {5'd0, 5'(i)};
            #1;
            chk("clr_zero", rdata[63:0], 64'h0);
        end

        // Depth-16 instance: out-of-range index ignored
        step();
        we0_s = 1; wa0_s = 20; wd0_s = 5;
        we1_s = 1; wa1_s = 15; wd1_s = 7;
        rsv_s = 1; rsva_s = 20;
        step();
        we0_s = 0; we1_s = 0; rsv_s = 0;
        raddr_s = {5'd15, 5'd20};
        @(negedge clk);
        chk("n16_x20", 64'(rdata_s[31:0]), 64'h0);
        chk("n16_x15", 64'(rdata_s[63:32]), 64'h7);
        chk("n16_pend", 64'(pend_s), 64'h0);

        // Reset in the middle of a clear
        step();
        we0 = 1; wa0 = 5; wd0 = 64'h55;
        step();
        we0 = 0; clear = 1; clear_s = 1;
        step();
        clear = 0; clear_s = 0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("mid_busy", 64'(busy), 64'h1);
        chk("mid_busy16", 64'(busy_s), 64'h1);
        rstn = 0;
        raddr = {5'd1, 5'd5};
        #1;
        chk("arst_busy", 64'(busy), 64'h0);
        chk("arst_busy16", 64'(busy_s), 64'h0);
        chk("arst_x5", rdata[63:0], 64'h0);
        chk("arst_x1", rdata[127:64], 64'h0);
        chk("arst_x15_16", 64'(rdata_s[63:32]), 64'h0);
        chk("arst_pend", 64'(pend), 64'h0);
        step();
        rstn = 1;
        @(negedge clk);
        chk("post_busy", 64'(busy), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
